codec_init_sequencer: RTL
=========================

// Module: codec_init_sequencer
// PURPOSE
//   Table-driven WM8731 configuration engine with parametrised entry count, NACK retry and re-run.
//   Walks NUM_REGS 16-bit entries {reg_addr[6:0], data[8:0]} from an external table (ROM/LUT).
//   Each entry becomes one two-byte I2C write through the byte-level I2C controller handshake.
//   Sits between the reset/top level and i2c_controller; done gates the audio datapath enable.
// PARAMETERS
//   NUM_REGS       11         number of table entries (1..255); cfg_index runs 0..NUM_REGS-1
//   PERIPH_ADDR    7'b0011010 7-bit I2C peripheral address (CSB=0)
//   STARTUP_CYCLES 1000       clk cycles to wait after reset before the first transaction (>=1)
//   MAX_RETRIES    3          extra attempts per entry after a NACK before error (0..15)
//   RETRY_GAP      64         idle clk cycles between a NACK and the retry of that entry (>=1)
//   AUTO_START     1          1: run automatically after reset; 0: wait in IDLE for start
// PORTS
//   clk         in   1   clock
//   reset       in   1   asynchronous, active-high reset
//   start       in   1   1-cycle pulse; (re)runs the table from entry 0; honoured in IDLE/DONE/ERROR only
//   cfg_index   out  8   table entry currently addressed
//   cfg_word    in   16  table data for cfg_index, combinational, valid same cycle
//   ctl_enable  out  1   1-cycle request pulse to the I2C controller
//   ctl_mode    out  1   1 = write; constant 1
//   ctl_addr    out  7   peripheral address; constant PERIPH_ADDR
//   ctl_byte    out  8   byte to transmit; stable from the ctl_enable cycle until ctl_ready returns
//   ctl_ready   in   1   controller idle/complete
//   ctl_nack    in   1   NACK flag for the last byte; valid whenever ctl_ready=1
//   busy        out  1   sequence in progress (any state other than IDLE/DONE/ERROR)
//   done        out  1   all entries written; held until start or reset
//   error       out  1   retries exhausted; held until start or reset
//   state_info  out  4   current state encoding, for debug LEDs
// BEHAVIOUR
//   Reset: state, cfg_index, ctl_byte, counters = 0; ctl_enable, busy, done, error = 0.
//   All outputs registered. Reset mid-transaction drops ctl_enable the same instant; no resume.
//   States (encoding) and transitions:
//     IDLE(0)     -> PWRUP if AUTO_START and first cycle after reset; -> FETCH on start
//     PWRUP(1)    count STARTUP_CYCLES, then -> FETCH
//     FETCH(2)    ctl_byte <= {cfg_word[15:9], cfg_word[8]}; -> SEND_HI
//     SEND_HI(3)  ctl_enable=1 for this cycle only; -> WAIT_HI
//     WAIT_HI(4)  arm on first ctl_ready=0; when armed and ctl_ready=1:
//                   ctl_nack=0 -> SEND_LO with ctl_byte <= cfg_word[7:0]
//                   ctl_nack=1 -> RETRY
//     SEND_LO(5)  ctl_enable=1 one cycle; -> WAIT_LO
//     WAIT_LO(6)  same arm/complete rule; ack -> NEXT; nack -> RETRY
//     NEXT(7)     retry_cnt <= 0; last entry -> DONE, else cfg_index+1 -> FETCH
//     RETRY(8)    retry_cnt = MAX_RETRIES -> ERROR; else wait RETRY_GAP cycles,
//                   retry_cnt+1, -> FETCH; the entry restarts from its high byte
//     DONE(9)     done=1; start -> clear done, cfg_index <= 0, -> FETCH (no PWRUP)
//     ERROR(10)   error=1; cfg_index frozen on the failing entry; start as for DONE
//   Arm rule: ctl_ready may still be 1 in the cycle after enable; completion needs a 0->1 edge.
//   start pulses while busy=1 are ignored, with no queueing.
//   Latency for one NACK-free entry: 3 + 2*(controller byte time + 1) cycles.
//   cfg_index wraps never: it saturates at NUM_REGS-1; widths: counters sized by $clog2.
// TESTING
//   T1 reset, AUTO_START=1, NUM_REGS=3, controller model always ACKs
//      -> 6 enable pulses after STARTUP_CYCLES; bytes {R0h,R0l,...}; done=1; busy=0.
//   T2 entry 1 = {7'h0F,9'h000}
//      -> bytes 8'h1E then 8'h00 with ctl_addr=7'h1A, ctl_mode=1.
//   T3 NACK on entry 1 low byte twice, then ACK
//      -> entry 1 resent from high byte after RETRY_GAP each time; done=1; error=0.
//   T4 NACK forever on entry 2, MAX_RETRIES=3
//      -> exactly 4 attempts; error=1; cfg_index=2; no further enables.
//   T5 ctl_ready held 1 for 2 cycles after enable
//      -> no false completion; advance only after a 0->1 edge.
//   T6 reset asserted during WAIT_LO, then start pulse mid-run and in DONE
//      -> outputs zero immediately; busy-time start ignored; DONE start reruns from entry 0.

Source files
------------

// File: rtl/codec_init_sequencer.sv
// Table-driven WM8731 register loader: walks NUM_REGS {addr,data} words and
// issues each one as a two-byte write through the byte-level I2C controller.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   start           1-cycle pulse, (re)runs the table; honoured in IDLE/DONE/ERROR
//   cfg_index       table entry currently addressed
//   cfg_word        table data for cfg_index, combinational
//   ctl_enable      1-cycle request pulse to the I2C controller
//   ctl_mode        write mode, constant 1
//   ctl_addr        peripheral address, constant PERIPH_ADDR
//   ctl_byte        byte to transmit, stable until the controller completes
//   ctl_ready       controller idle/complete
//   ctl_nack        NACK flag for the last byte, valid while ctl_ready=1
//   busy            sequence in progress
//   done            all entries written, held until start/reset
//   error           retries exhausted, held until start/reset
//   state_info      current state encoding for debug LEDs
module codec_init_sequencer #(
    parameter int         NUM_REGS       = 11,
    parameter logic [6:0] PERIPH_ADDR    = 7'b0011010,
    parameter int         STARTUP_CYCLES = 1000,
    parameter int         MAX_RETRIES    = 3,
    parameter int         RETRY_GAP      = 64,
    parameter bit         AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  cfg_index,
    input  logic [15:0] cfg_word,
    output logic        ctl_enable,
    output logic        ctl_mode,
    output logic [6:0]  ctl_addr,
    output logic [7:0]  ctl_byte,
    input  logic        ctl_ready,
    input  logic        ctl_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  state_info
);

    localparam int CNT_TOP = (STARTUP_CYCLES > RETRY_GAP) ? STARTUP_CYCLES
                                                          : RETRY_GAP;
    localparam int CW = $clog2(CNT_TOP + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(RETRY_GAP - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);
    localparam logic [7:0]    LAST_INDEX   = 8'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PWRUP   = 4'd1,
        S_FETCH   = 4'd2,
        S_SEND_HI = 4'd3,
        S_WAIT_HI = 4'd4,
        S_SEND_LO = 4'd5,
        S_WAIT_LO = 4'd6,
        S_NEXT    = 4'd7,
        S_RETRY   = 4'd8,
        S_DONE    = 4'd9,
        S_ERROR   = 4'd10
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      index_q, index_d;
    logic [7:0]      byte_q, byte_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            armed_q, armed_d;
    logic            first_q;
    logic            enable_q, enable_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            index_q  <= 8'd0;
            byte_q   <= 8'd0;
            retry_q  <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            first_q  <= 1'b1;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            byte_q   <= byte_d;
            retry_q  <= retry_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            first_q  <= 1'b0;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        byte_d  = byte_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        armed_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (AUTO_START && first_q) begin
                    state_d = S_PWRUP;
                end else if (start) begin
                    state_d = S_FETCH;
                    index_d = 8'd0;
                    retry_d = '0;
                end
            end
            S_PWRUP: begin
                if (cnt_q == STARTUP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FETCH: begin
                byte_d  = {cfg_word[15:9], cfg_word[8]};
                state_d = S_SEND_HI;
            end
            S_SEND_HI: state_d = S_WAIT_HI;
            S_SEND_LO: state_d = S_WAIT_LO;
            S_WAIT_HI, S_WAIT_LO: begin
                // ready may linger high right after the request, so a
                // completion only counts once ready has been seen low
                armed_d = armed_q | ~ctl_ready;
                if (armed_q && ctl_ready) begin
                    armed_d = 1'b0;
                    if (ctl_nack) begin
                        state_d = S_RETRY;
                    end else if (state_q == S_WAIT_HI) begin
                        byte_d  = cfg_word[7:0];
                        state_d = S_SEND_LO;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (index_q == LAST_INDEX) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            S_RETRY: begin
                if (retry_q == RETRY_LIMIT) begin
                    state_d = S_ERROR;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    retry_d = retry_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_FETCH;
                    index_d = 8'd0;
                    retry_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // status flags follow the next state so they are registered
        // and line up with the state they describe
        enable_d = (state_d == S_SEND_HI) || (state_d == S_SEND_LO);
        done_d   = (state_d == S_DONE);
        error_d  = (state_d == S_ERROR);
        busy_d   = !((state_d == S_IDLE) || (state_d == S_DONE) ||
                     (state_d == S_ERROR));
    end

    assign cfg_index  = index_q;
    assign ctl_enable = enable_q;
    assign ctl_mode   = 1'b1;
    assign ctl_addr   = PERIPH_ADDR;
    assign ctl_byte   = byte_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign state_info = state_q;

endmodule
